// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared instruction/data memory.
// Port 0 is the CPU and port 1 is the loader/debug port. Only one access is in
// flight at a time. Ties are broken round-robin. Bad mode or misaligned word
// accesses are rejected without touching memory. A stalled memory is aborted
// after TIMEOUT wait cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        mode0,
    input  logic [1:0]        mode1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              grant,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                rr_last;
    logic [7:0]          cnt;
    logic                we_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                grant_q;

    logic                any_req;
    logic                tie;
    logic                pick;
    logic                sel_we;
    logic [1:0]          sel_mode;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                bad_req;
    logic                timed_out;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Arbitration, request checking and next-state selection
    always_comb begin
        any_req   = req0 | req1;
        tie       = req0 & req1;
        pick      = tie ? ~rr_last : req1;
        sel_we    = pick ? we1    : we0;
        sel_mode  = pick ? mode1  : mode0;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
        bad_req   = (sel_mode == 2'b11) ||
                    ((sel_mode == 2'b00) && (sel_addr[1:0] != 2'b00));
        timed_out = (cnt == CNT_LAST);
        state_nxt = state;
        case (state)
            S_IDLE: if (any_req) state_nxt = bad_req ? S_DONE : S_WAIT;
            S_WAIT: if (mem_ready || timed_out) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, round-robin pointer, wait counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
            cnt     <= '0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_q <= pick;
                        we_q    <= sel_we;
                        mode_q  <= sel_mode;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (tie) rr_last <= pick;
                        if (bad_req) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    // A ready in the final wait cycle still completes normally
                    if (mem_ready) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    // Port-side and memory-side outputs decoded from state
    always_comb begin
        busy      = (state != S_IDLE);
        mem_req   = (state == S_WAIT);
        mem_we    = mem_req & we_q;
        mem_mode  = mem_req ? mode_q  : '0;
        mem_addr  = mem_req ? addr_q  : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        ack0      = (state == S_DONE) & ~grant_q;
        ack1      = (state == S_DONE) &  grant_q;
        rdata     = rdata_q;
        err       = err_q;
        grant     = grant_q;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- Port 0 is the multicycle CPU controller/datapath, which issues fetch and load/store accesses. Port 1 is the program loader/debug port.
- Registers one request at a time, drives the memory with a ready handshake, and returns data plus a one-cycle acknowledge to the granted port.
- Uses round-robin arbitration, checks access mode and alignment, and guards against a stalled memory with a timeout.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum WAIT cycles before an access is aborted with error; legal range 2..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  request from port 0 (CPU) / port 1 (loader); held high until that port's ack
- we0, we1  in  1  1 = write, 0 = read
- mode0, mode1  in  2  2'b00 word, 2'b01 signed byte, 2'b10 unsigned byte, 2'b11 reserved
- addr0, addr1  in  ADDR_W  byte address
- wdata0, wdata1  in  DATA_W  write data
- ack0, ack1  out  1  one-cycle completion pulse to port 0 / 1
- rdata  out  DATA_W  read data, valid while ackN=1
- err  out  1  access failed, valid while ackN=1
- busy  out  1  high in any state other than IDLE
- grant  out  1  port owning the current access
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_mode  out  2  forwarded mode
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completion

Behaviour:
- Reset: state=IDLE, rr_last=1 so port 0 wins the first tie, timeout counter=0.
  - All outputs 0: ack0, ack1, err, busy, grant, mem_req, mem_we, mem_mode, mem_addr, mem_wdata, rdata.
- Reset mid-operation aborts the access with no ack. mem_req is low in the cycle after the reset edge.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If exactly one reqN is high at the edge, grant it.
  - If both are high, grant the port not equal to rr_last, then set rr_last to the granted port.
  - Latch we, mode, addr and wdata of the granted port into internal registers.
  - Check the request:
    - mode==2'b11: skip WAIT, go to DONE with err=1.
    - Word mode with addr[1:0]!=0: skip WAIT, go to DONE with err=1.
    - Otherwise go to WAIT.
  - If no request: stay in IDLE.
- WAIT:
  - mem_req=1. mem_we, mem_mode, mem_addr and mem_wdata are driven from the latched registers and are stable for the whole WAIT.
  - mem_ready=1: capture mem_rdata (reads; writes capture 0), err=0, go to DONE.
  - The counter increments each WAIT cycle. If mem_ready is still low when the counter reaches TIMEOUT-1, go to DONE with err=1 and rdata=0.
- DONE:
  - Assert ack of the granted port for exactly one cycle; the other ack stays 0. rdata and err are held valid.
  - Go to IDLE and clear the counter.
  - rdata and err hold their value until the next DONE.
- Outputs mem_* are 0 outside WAIT.
- Requester rule: drop reqN at the edge ending the ack cycle.
  - A req still high in the following IDLE is treated as a new request.
- Minimum latency, req high to ack: 3 cycles (IDLE, WAIT with mem_ready=1, DONE).
  - Latency with k memory wait cycles: 3+k.
  - A rejected mode or alignment access takes 2 cycles.
- Back-to-back accesses with both ports requesting continuously alternate 0,1,0,1.
- A request arriving while busy waits. The arbiter never preempts and never drops it.
- Byte extension is done by the memory according to mem_mode. The arbiter passes mem_rdata through unmodified.

Test Plan:
- Port 0 read word at 0x00000010, memory returns 0xDEADBEEF with mem_ready in the first WAIT cycle -> ack0 in cycle 3 after req, rdata=0xDEADBEEF, err=0, ack1=0.
- req0 and req1 high together right after reset, both held and re-requested -> grant sequence 0,1,0,1. Each ack is a single-cycle pulse; mem_req never overlaps DONE.
- Port 1 write word 0x12345678 to 0x20, mem_ready delayed 4 cycles -> mem_addr, mem_wdata and mem_we stable for all 5 WAIT cycles; ack1 at cycle 7; err=0.
- mode0=2'b00 with addr=0x00000002, then mode0=2'b11 with addr=0x4 -> each gives ack0 2 cycles after req with err=1 and no mem_req pulse.
- Port 0 read with mem_ready held low, TIMEOUT=16 -> exactly 16 mem_req cycles, then ack0 with err=1 and rdata=0.
- Reset asserted in the 2nd WAIT cycle -> mem_req=0 and busy=0 the next cycle, no ack issued, next grant goes to port 0 on a tie.
